// File: rtl/smi_pkg.sv
// rtl/smi_pkg.sv - shared SMI/AXI read constants, field widths and splitter state type
package smi_pkg;

    localparam logic [7:0] READ_RESP_ID_BYTE = 8'h21;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_4B  = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B  = 3'd3;
    localparam logic [2:0] AXI_SIZE_16B = 3'd4;
    localparam logic [2:0] AXI_SIZE_32B = 3'd5;
    localparam logic [2:0] AXI_SIZE_64B = 3'd6;

    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_BITS  = 12;

    localparam int DESC_TAG_W    = 16;
    localparam int DESC_OFFSET_W = 8;
    localparam int DESC_BYTES_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ZERO_DESC,
        ST_CALC,
        ST_ISSUE
    } splitState_t;

endpackage

// File: rtl/smi_axi_burst_calc.sv
// rtl/smi_axi_burst_calc.sv - combinational size/len calculator for one AXI INCR burst
module smi_axi_burst_calc
    import smi_pkg::*;
#(
    parameter int DataIndexSize = 4,
    parameter int MaxBurstBeats = 16
) (
    input  logic [PAGE_BITS-1:0]     addrLow,
    input  logic [DESC_BYTES_W-1:0]  remaining,
    output logic [DESC_OFFSET_W-1:0] offset,
    output logic [DESC_BYTES_W-1:0]  bytes,
    output logic [7:0]               len,
    output logic                     last
);

    localparam int BeatBytes = 1 << DataIndexSize;

    logic [16:0] off17;
    logic [16:0] lim4k;
    logic [16:0] limBurst;
    logic [16:0] rem17;
    logic [16:0] minLim;
    logic [16:0] bytes17;
    logic [16:0] endOff;

    // 17 bits hold a full 4096-byte page limit next to a 16-bit remaining count
    always_comb begin
        off17    = {5'd0, addrLow & PAGE_BITS'(BeatBytes - 1)};
        lim4k    = 17'(PAGE_BYTES) - {5'd0, addrLow};
        limBurst = 17'(MaxBurstBeats * BeatBytes) - off17;
        rem17    = {1'b0, remaining};
        minLim   = (lim4k < limBurst) ? lim4k : limBurst;
        bytes17  = (rem17 < minLim) ? rem17 : minLim;
        endOff   = off17 + bytes17 - 17'd1;
        offset   = off17[DESC_OFFSET_W-1:0];
        bytes    = bytes17[DESC_BYTES_W-1:0];
        len      = 8'(endOff >> DataIndexSize);
        last     = (bytes17 == rem17);
    end

endmodule

// File: rtl/smi_axi_read_burst_splitter.sv
// rtl/smi_axi_read_burst_splitter.sv - splits one SMI read into 4KB-safe AXI INCR bursts plus descriptors
module smi_axi_read_burst_splitter
    import smi_pkg::*;
#(
    parameter int DataIndexSize  = 4,
    parameter int AxiIdWidth     = 4,
    parameter int AxiIdValue     = 0,
    parameter int MaxBurstBeats  = 16,
    parameter int MaxOutstanding = 8
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     reqReady,
    input  logic [63:0]              reqAddr,
    input  logic [15:0]              reqLength,
    input  logic [DESC_TAG_W-1:0]    reqTag,
    output logic                     reqStop,
    output logic                     axiARValid,
    input  logic                     axiARReady,
    output logic [AxiIdWidth-1:0]    axiARId,
    output logic [63:0]              axiARAddr,
    output logic [7:0]               axiARLen,
    output logic [2:0]               axiARSize,
    output logic                     descReady,
    input  logic                     descStop,
    output logic [DESC_TAG_W-1:0]    descTag,
    output logic [DESC_OFFSET_W-1:0] descOffset,
    output logic [DESC_BYTES_W-1:0]  descBytes,
    output logic                     descLast,
    input  logic                     burstDone
);

    localparam int         BeatBytes = 1 << DataIndexSize;
    localparam logic [7:0] MaxOut8   = 8'(MaxOutstanding);

    splitState_t             state;
    logic [63:0]             curAddr;
    logic [15:0]             remaining;
    logic                    arDone;
    logic                    descDone;
    logic [7:0]              outstanding;

    logic [DESC_OFFSET_W-1:0] calcOffset;
    logic [DESC_BYTES_W-1:0]  calcBytes;
    logic [7:0]               calcLen;
    logic                     calcLast;
    logic                     arFire;
    logic                     descFire;

    assign arFire    = axiARValid & axiARReady;
    assign descFire  = descReady & ~descStop;
    assign axiARId   = AxiIdWidth'(AxiIdValue);
    assign axiARSize = 3'(DataIndexSize);

    smi_axi_burst_calc #(
        .DataIndexSize (DataIndexSize),
        .MaxBurstBeats (MaxBurstBeats)
    ) burstCalc (
        .addrLow   (curAddr[PAGE_BITS-1:0]),
        .remaining (remaining),
        .offset    (calcOffset),
        .bytes     (calcBytes),
        .len       (calcLen),
        .last      (calcLast)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            curAddr    <= '0;
            remaining  <= '0;
            arDone     <= 1'b0;
            descDone   <= 1'b0;
            reqStop    <= 1'b1;
            axiARValid <= 1'b0;
            axiARAddr  <= '0;
            axiARLen   <= '0;
            descReady  <= 1'b0;
            descTag    <= '0;
            descOffset <= '0;
            descBytes  <= '0;
            descLast   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reqReady && !reqStop) begin
                        curAddr   <= reqAddr;
                        remaining <= reqLength;
                        descTag   <= reqTag;
                        reqStop   <= 1'b1;
                        if (reqLength == 16'd0) begin
                            descReady  <= 1'b1;
                            descOffset <= DESC_OFFSET_W'(reqAddr[7:0] & 8'(BeatBytes - 1));
                            descBytes  <= '0;
                            descLast   <= 1'b1;
                            state      <= ST_ZERO_DESC;
                        end else begin
                            state <= ST_CALC;
                        end
                    end else begin
                        reqStop <= 1'b0;
                    end
                end
                ST_ZERO_DESC: begin
                    if (descFire) begin
                        descReady <= 1'b0;
                        reqStop   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // calc results stay valid while waiting, since curAddr/remaining are held
                    if (outstanding < MaxOut8) begin
                        axiARValid <= 1'b1;
                        axiARAddr  <= curAddr;
                        axiARLen   <= calcLen;
                        descReady  <= 1'b1;
                        descOffset <= calcOffset;
                        descBytes  <= calcBytes;
                        descLast   <= calcLast;
                        arDone     <= 1'b0;
                        descDone   <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (arFire) begin
                        axiARValid <= 1'b0;
                        arDone     <= 1'b1;
                    end
                    if (descFire) begin
                        descReady <= 1'b0;
                        descDone  <= 1'b1;
                    end
                    if ((arDone || arFire) && (descDone || descFire)) begin
                        curAddr   <= curAddr + 64'(descBytes);
                        remaining <= remaining - descBytes;
                        if (descLast) begin
                            reqStop <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // a burstDone in the same cycle as an AR transfer cancels it out
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            outstanding <= '0;
        end else if (arFire && !burstDone) begin
            outstanding <= outstanding + 8'd1;
        end else if (!arFire && burstDone && outstanding != 8'd0) begin
            outstanding <= outstanding - 8'd1;
        end
    end

endmodule

// File: tb/tb_smi_axi_read_burst_splitter.sv
// tb/tb_smi_axi_read_burst_splitter.sv - self-checking bench for smi_axi_read_burst_splitter
module tb_smi_axi_read_burst_splitter;

    localparam int MAXOUT = 2;
    localparam int BEAT   = 16;
    localparam int MAXB   = 16 * BEAT;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [7:0]  off;
        logic [15:0] bytes;
        logic        last;
    } burst_t;
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;
    typedef struct {
        logic [15:0] tag;
        logic [7:0]  off;
        logic [15:0] bytes;
        logic        last;
    } desc_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        reqReady;
    logic [63:0] reqAddr;
    logic [15:0] reqLength;
    logic [15:0] reqTag;
    logic        reqStop;
    logic        axiARValid;
    logic        axiARReady;
    logic [3:0]  axiARId;
    logic [63:0] axiARAddr;
    logic [7:0]  axiARLen;
    logic [2:0]  axiARSize;
    logic        descReady;
    logic        descStop;
    logic [15:0] descTag;
    logic [7:0]  descOffset;
    logic [15:0] descBytes;
    logic        descLast;
    logic        burstDone;

    int     vecs = 0;
    int     miss = 0;
    int     cnt = 0;
    bit     autoDone = 0;
    bit     rndHs = 0;
    burst_t expQ[$];
    ar_t    arQ[$];
    desc_t  descQ[$];
    logic [15:0] expTag;

    always #5 clk = ~clk;

    smi_axi_read_burst_splitter #(
        .DataIndexSize  (4),
        .AxiIdWidth     (4),
        .AxiIdValue     (0),
        .MaxBurstBeats  (16),
        .MaxOutstanding (MAXOUT)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .reqReady   (reqReady),
        .reqAddr    (reqAddr),
        .reqLength  (reqLength),
        .reqTag     (reqTag),
        .reqStop    (reqStop),
        .axiARValid (axiARValid),
        .axiARReady (axiARReady),
        .axiARId    (axiARId),
        .axiARAddr  (axiARAddr),
        .axiARLen   (axiARLen),
        .axiARSize  (axiARSize),
        .descReady  (descReady),
        .descStop   (descStop),
        .descTag    (descTag),
        .descOffset (descOffset),
        .descBytes  (descBytes),
        .descLast   (descLast),
        .burstDone  (burstDone)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the request in page/burst-sized chunks with plain arithmetic
    task automatic buildModel(input logic [63:0] a, input int len, input logic [15:0] tg);
        logic [63:0] cur;
        int rem, off, pageLeft, bytes;
        burst_t b;
        expQ.delete();
        expTag = tg;
        cur = a;
        rem = len;
        if (len == 0) begin
            b.addr = a; b.len = 0; b.off = 8'(a % 64'd16); b.bytes = 0; b.last = 1;
            expQ.push_back(b);
        end
        while (rem > 0) begin
            off      = int'(cur % 64'(BEAT));
            pageLeft = 4096 - int'(cur % 64'd4096);
            bytes    = rem;
            if (pageLeft < bytes) bytes = pageLeft;
            if (MAXB - off < bytes) bytes = MAXB - off;
            b.addr  = cur;
            b.len   = 8'((off + bytes + BEAT - 1) / BEAT - 1);
            b.off   = 8'(off);
            b.bytes = 16'(bytes);
            b.last  = (bytes == rem);
            expQ.push_back(b);
            cur = cur + 64'(bytes);
            rem = rem - bytes;
        end
    endtask

    task automatic tick();
        bit arF, dF;
        ar_t  ar;
        desc_t d;
        @(negedge clk);
        arF = axiARValid && axiARReady;
        dF  = descReady && !descStop;
        check("ar_without_credit", {63'd0, axiARValid && (cnt >= MAXOUT)}, 64'd0);
        if (arF) begin
            ar.addr = axiARAddr; ar.len = axiARLen;
            arQ.push_back(ar);
        end
        if (dF) begin
            d.tag = descTag; d.off = descOffset; d.bytes = descBytes; d.last = descLast;
            descQ.push_back(d);
        end
        if (arF && !burstDone) cnt++;
        else if (!arF && burstDone && cnt > 0) cnt--;
        @(posedge clk);
        #1;
        if (autoDone) burstDone = (cnt > 0) && ($urandom_range(0, 2) == 0);
        if (rndHs) begin
            axiARReady = ($urandom_range(0, 3) != 0);
            descStop   = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic startReq(input logic [63:0] a, input logic [15:0] l, input logic [15:0] tg);
        int n;
        buildModel(a, int'(l), tg);
        arQ.delete();
        descQ.delete();
        for (n = 0; n < 50 && reqStop; n++) tick();
        check("req_idle", {63'd0, reqStop}, 64'd0);
        reqAddr = a; reqLength = l; reqTag = tg; reqReady = 1'b1;
        tick();
        reqReady = 1'b0;
        reqAddr = {$urandom, $urandom};
        reqLength = 16'($urandom);
    endtask

    task automatic finishReq();
        int n, nAr;
        nAr = 0;
        foreach (expQ[i]) if (expQ[i].bytes != 0) nAr++;
        for (n = 0; n < 4000; n++) begin
            if (descQ.size() >= expQ.size() && arQ.size() >= nAr && !reqStop) break;
            tick();
        end
        check("req_complete_in_time", {63'd0, n < 4000}, 64'd1);
        check("ar_count", 64'(arQ.size()), 64'(nAr));
        check("desc_count", 64'(descQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < descQ.size(); i++) begin
            check("desc_tag", 64'(descQ[i].tag), 64'(expTag));
            check("desc_offset", 64'(descQ[i].off), 64'(expQ[i].off));
            check("desc_bytes", 64'(descQ[i].bytes), 64'(expQ[i].bytes));
            check("desc_last", 64'(descQ[i].last), 64'(expQ[i].last));
            if (i < arQ.size() && expQ[i].bytes != 0) begin
                check("ar_addr", arQ[i].addr, expQ[i].addr);
                check("ar_len", 64'(arQ[i].len), 64'(expQ[i].len));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        nreset = 1'b0; reqReady = 1'b0; reqAddr = '0; reqLength = '0; reqTag = '0;
        axiARReady = 1'b1; descStop = 1'b0; burstDone = 1'b0;
        #12;
        check("rst_reqStop", {63'd0, reqStop}, 64'd1);
        check("rst_arvalid", {63'd0, axiARValid}, 64'd0);
        check("rst_descready", {63'd0, descReady}, 64'd0);
        check("rst_arsize", 64'(axiARSize), 64'd4);
        check("rst_arid", 64'(axiARId), 64'd0);
        check("rst_araddr", axiARAddr, 64'd0);
        check("rst_descbytes", 64'(descBytes), 64'd0);
        @(posedge clk); #3; nreset = 1'b1;
        @(posedge clk); #1;

        autoDone = 1;
        startReq(64'h1000, 16'd64, 16'hA001);
        check("lat_cycle1_ar", {63'd0, axiARValid}, 64'd0);
        check("lat_cycle1_desc", {63'd0, descReady}, 64'd0);
        tick();
        check("lat_cycle2_ar", {63'd0, axiARValid}, 64'd1);
        check("lat_cycle2_desc", {63'd0, descReady}, 64'd1);
        finishReq();

        startReq(64'h0FF0, 16'd48, 16'hA002);
        finishReq();
        startReq(64'h2004, 16'd600, 16'hA003);
        finishReq();
        startReq(64'hFFFF_FFFF_FFFF_FFF0, 16'd64, 16'hA004);
        finishReq();
        startReq(64'h0000_0000_0000_7ABC, 16'd0, 16'hA005);
        finishReq();

        descStop = 1'b1;
        startReq(64'h3000, 16'd32, 16'hA006);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_desc_held", {63'd0, descReady}, 64'd1);
            check("bp_desc_bytes", 64'(descBytes), 64'd32);
            check("bp_ar_dropped", {63'd0, axiARValid}, 64'd0);
            check("bp_ar_once", 64'(arQ.size()), 64'd1);
        end
        descStop = 1'b0;
        finishReq();

        autoDone = 0; burstDone = 1'b0; axiARReady = 1'b0;
        startReq(64'h4000, 16'd512, 16'hA007);
        tick();
        check("pre_reset_arvalid", {63'd0, axiARValid}, 64'd1);
        #2; nreset = 1'b0; #1;
        check("async_rst_arvalid", {63'd0, axiARValid}, 64'd0);
        check("async_rst_descready", {63'd0, descReady}, 64'd0);
        check("async_rst_reqstop", {63'd0, reqStop}, 64'd1);
        cnt = 0;
        @(posedge clk); #3; nreset = 1'b1; axiARReady = 1'b1;
        @(posedge clk); #1;

        startReq(64'h0, 16'd1280, 16'hA008);
        repeat (30) tick();
        check("credit_stall_count", 64'(arQ.size()), 64'd2);
        check("credit_stall_arvalid", {63'd0, axiARValid}, 64'd0);
        burstDone = 1'b1; tick(); burstDone = 1'b0;
        for (n = 0; n < 10 && arQ.size() < 3; n++) tick();
        check("credit_third_ar", 64'(arQ.size()), 64'd3);
        repeat (10) tick();
        check("credit_stall_again", 64'(arQ.size()), 64'd3);
        burstDone = 1'b1; tick(); burstDone = 1'b0;
        for (n = 0; n < 10; n++) begin
            if (axiARValid) begin
                burstDone = 1'b1; tick(); burstDone = 1'b0;
                break;
            end
            tick();
        end
        for (n = 0; n < 20 && arQ.size() < 5; n++) tick();
        check("credit_coincide_fifth_ar", 64'(arQ.size()), 64'd5);
        autoDone = 1;
        finishReq();

        rndHs = 1;
        for (int r = 0; r < 12; r++) begin
            logic [63:0] a;
            logic [15:0] l;
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: a[11:0] = 12'hFF0 | 12'($urandom_range(0, 15));
                1: a = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
                default: ;
            endcase
            l = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1200));
            startReq(a, l, 16'($urandom));
            finishReq();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/smi_axi_read_burst_splitter.md
Name: smi_axi_read_burst_splitter

Overview:
Next-generation request side for SMI-to-AXI reads. It accepts one decoded SMI read request (address, byte length, tag) and splits it into legal AXI INCR bursts. Bursts are limited by MaxBurstBeats and never cross a 4KB boundary. For each burst it emits one descriptor to the response-side packer/header injector, and it throttles issue with an outstanding-burst credit counter.

Parameters:
DataIndexSize, 4, log2 of bytes per beat; bytes per beat B = 1<<DataIndexSize; legal range 2..6.
AxiIdWidth, 4, width of axiARId.
AxiIdValue, 0, fixed ID for every burst, which keeps responses in order.
MaxBurstBeats, 16, beats per burst, 1..256; MaxBurstBeats*B must be <= 4096.
MaxOutstanding, 8, maximum AR bursts issued without a matching burstDone; 1..255.

Ports:
clk in 1 clock
nreset in 1 asynchronous active-low reset
reqReady in 1 request valid
reqAddr in 64 start byte address
reqLength in 16 byte count
reqTag in 16 SMI tag
reqStop out 1 request backpressure
axiARValid out 1 AR valid
axiARReady in 1 AR ready
axiARId out AxiIdWidth equals AxiIdValue
axiARAddr out 64 burst byte address (unaligned on first burst)
axiARLen out 8 beats-1
axiARSize out 3 DataIndexSize[2:0], constant
descReady out 1 descriptor valid
descStop in 1 descriptor backpressure
descTag out 16 reqTag
descOffset out 8 addr mod B of burst start
descBytes out 16 bytes in burst
descLast out 1 final burst of request
burstDone in 1 pulse per completed burst (RLAST beat accepted)

Behaviour:
- Reset: while nreset=0, all state clears asynchronously. Every output is 0 except reqStop=1 and axiARSize=DataIndexSize.
- Request handshake: transfer occurs when reqReady & ~reqStop. reqStop=0 only in Idle.
- Output handshakes:
  - AR transfers when axiARValid & axiARReady.
  - Descriptor transfers when descReady & ~descStop.
  - Valids hold and payloads stay stable until accepted.
- FSM Idle -> Calc -> Issue -> (Calc | Idle):
  - Idle: on request transfer, register curAddr=reqAddr, remaining=reqLength, tag.
    - If reqLength=0: go to ZeroDesc, which emits one descriptor (bytes 0, offset reqAddr mod B, last 1), issues no AR and consumes no credit, then returns to Idle.
  - Calc (1 cycle):
    - off = curAddr mod B
    - lim4k = 4096 - curAddr[11:0]
    - limBurst = MaxBurstBeats*B - off
    - bytes = min(remaining, lim4k, limBurst)
    - len = (off + bytes - 1) >> DataIndexSize
    - last = (bytes == remaining)
    - Use 17-bit intermediates; no truncation is permitted.
  - Issue:
    - Entering Issue requires outstanding < MaxOutstanding; otherwise wait in Calc with results held.
    - On entry, axiARValid and descReady both assert in the same cycle.
    - Each output drops independently when accepted (per-channel done flags).
    - When both are done: curAddr += bytes, remaining -= bytes; go to Idle if last, else Calc.
- Latency: reqReady accepted at cycle 0 -> first axiARValid/descReady at cycle 2.
- Credit counter:
  - +1 on AR transfer, -1 on burstDone; simultaneous events leave it unchanged.
  - burstDone when count=0 is ignored (saturates at 0).
  - The count never exceeds MaxOutstanding.
- Addresses: curAddr is 64-bit with wrap-around at 2^64 (no special case). The 4KB rule always uses the low 12 bits.

Decomposition:
- Shared package smi_pkg:
  - READ_RESP_ID_BYTE
  - AXI size/burst encodings
  - 4096 page constant
  - descriptor field widths
- One natural sub-module: smi_axi_burst_calc. It is a combinational min/len calculator, parametrised on DataIndexSize and MaxBurstBeats, and is reusable by the write-side splitter.

Test Plan:
1. addr 0x1000, len 64, B=16 -> one AR {addr 0x1000, len 3}; descriptor {off 0, bytes 64, last 1}; reqStop returns to 0.
2. addr 0x0FF0, len 48 -> AR {0x0FF0, len 0} with desc {off 0, bytes 16}, then AR {0x1000, len 1} with desc {bytes 32, last 1}; no burst crosses 4KB.
3. addr 0x2004, len 600, MaxBurstBeats 16 -> bursts:
   - {0x2004, len 15, bytes 252, off 4}
   - {0x2100, len 15, bytes 256}
   - {0x2200, len 5, bytes 92, last 1}
4. MaxOutstanding=2, addr 0, len 1024, burstDone held 0 -> exactly 2 AR transfers, then stall with axiARValid=0. A single burstDone pulse issues the third AR; a burstDone coinciding with an AR transfer leaves count=2.
5. Backpressure: descStop=1 for 5 cycles while axiARReady=1 -> AR accepted once and not reissued; descriptor stable; FSM advances only after descStop falls. Zero-length request -> one descriptor {bytes 0, last 1}, no AR.
6. nreset asserted mid-Issue with axiARValid=1 -> same-cycle (asynchronous) clear: axiARValid=0, descReady=0, reqStop=1, credit count=0. After release, a new request operates normally.
